// File: rtl/instructions_ram_loader.sv
// instructions_ram_loader
//   Instruction store with a registered fetch port, a direct single-word write
//   port and a burst loader that streams a program image into consecutive
//   addresses. The core is stalled for as long as the loader is busy.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   fetch_address/data    one-cycle-latency read port; fetch_valid marks data
//                         read while the loader was idle
//   stall                 high while the loader is in LOAD or DONE
//   write_enable/address/data  direct write, honoured only while idle
//   load_start/base/length     begin a burst (sampled together, idle only)
//   load_valid/data/ready      burst word stream
//   load_done             one-cycle pulse when the burst completes
//   range_error           sticky flag for any out-of-range fetch or write
//
// Handshake: a burst word transfers on every rising edge where load_valid and
// load_ready are both high. load_ready depends only on loader state, never on
// load_valid, and the source must hold load_data stable while load_valid is
// high and load_ready is low.
module instructions_ram_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  output logic                  stall,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [LEN_WIDTH-1:0]  load_length,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  range_error
);

  // Array index width; the range check guards every access, so only the low
  // bits of an address are ever used to select a word.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] ptr, next_ptr;
  logic [LEN_WIDTH-1:0]  remaining, next_remaining;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic accept;
  logic direct_wr;
  logic fetch_ok;
  logic write_ok;
  logic ptr_ok;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  assign load_ready = (state == LOAD);
  assign load_done  = (state == DONE);
  assign stall      = (state != IDLE);

  assign accept    = load_ready && load_valid;
  assign direct_wr = write_enable && (state == IDLE);
  assign fetch_ok  = in_range(fetch_address);
  assign write_ok  = in_range(write_address);
  assign ptr_ok    = in_range(ptr);

  // Next-state logic
  always_comb begin
    next_state     = state;
    next_ptr       = ptr;
    next_remaining = remaining;
    case (state)
      IDLE: begin
        if (load_start) begin
          next_ptr       = load_base;
          next_remaining = load_length;
          next_state     = (load_length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          next_ptr       = ptr + ADDR_WIDTH'(1);
          next_remaining = remaining - LEN_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      remaining <= next_remaining;
    end
  end

  // Storage. Direct writes and loader writes are exclusive by state. Contents
  // survive reset; only writes presented during reset are suppressed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (direct_wr && write_ok) begin
        mem[write_address[IDX_W-1:0]] <= write_data;
      end else if (accept && ptr_ok) begin
        mem[ptr[IDX_W-1:0]] <= load_data;
      end
    end
  end

  // Registered fetch; non-blocking update gives read-first on collisions.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_data  <= fetch_ok ? mem[fetch_address[IDX_W-1:0]] : '0;
      fetch_valid <= (state == IDLE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      range_error <= 1'b0;
    end else if (!fetch_ok || (direct_wr && !write_ok) || (accept && !ptr_ok)) begin
      range_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instructions_ram_loader.sv
// tb_instructions_ram_loader
//   Directed bench for instructions_ram_loader built with DEPTH=16 so that
//   out-of-range behaviour is reachable with short bursts. Inputs change and
//   outputs are sampled on the falling clock edge.
module tb_instructions_ram_loader;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int DEP = 16;
  localparam int LW  = 11;

  logic          clock;
  logic          reset;
  logic [AW-1:0] fetch_address;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          stall;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [LW-1:0] load_length;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          range_error;

  int n_vec;
  int n_err;

  instructions_ram_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .LEN_WIDTH(LW)
  ) dut (
    .clock(clock), .reset(reset),
    .fetch_address(fetch_address), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .stall(stall),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data),
    .load_start(load_start), .load_base(load_base), .load_length(load_length),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .range_error(range_error)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive_idle();
    fetch_address = '0;
    write_enable  = 1'b0;
    write_address = '0;
    write_data    = '0;
    load_start    = 1'b0;
    load_base     = '0;
    load_length   = '0;
    load_valid    = 1'b0;
    load_data     = '0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_enable  = 1'b1;
    write_address = a;
    write_data    = d;
    tick();
    write_enable  = 1'b0;
  endtask

  task automatic start_load(input logic [AW-1:0] base, input logic [LW-1:0] len);
    load_start  = 1'b1;
    load_base   = base;
    load_length = len;
    tick();
    load_start  = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) tick();
    n_vec++; if (fetch_data !== '0) begin n_err++; $display("FAIL reset_fetch_data: got %h want 0", fetch_data); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    n_vec++; if (range_error !== 1'b0) begin n_err++; $display("FAIL reset_range_error: got %b want 0", range_error); end
    reset = 1'b0;
    tick();
    n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_fetch_valid: got %b want 1", fetch_valid); end
  endtask

  task automatic test_direct_write();
    write_word(10'd5, 32'hDEADBEEF);
    fetch_address = 10'd5;
    tick();
    n_vec++; if (fetch_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL dw_fetch: got %h want deadbeef", fetch_data); end
    n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL dw_fetch_valid: got %b want 1", fetch_valid); end
    // Same-cycle write and read of address 5: old data first, new data next.
    write_enable = 1'b1; write_address = 10'd5; write_data = 32'h12345678;
    tick();
    write_enable = 1'b0;
    n_vec++; if (fetch_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL collision_old: got %h want deadbeef", fetch_data); end
    tick();
    n_vec++; if (fetch_data !== 32'h12345678) begin n_err++; $display("FAIL collision_new: got %h want 12345678", fetch_data); end
    fetch_address = '0;
    write_word(10'd4, 32'h44440004);
    write_word(10'd6, 32'h00000600);
  endtask

  task automatic test_burst();
    int ready_cnt;
    ready_cnt = 0;
    start_load(10'd8, 11'd4);
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL burst_stall_start: got %b want 1", stall); end
    for (int i = 0; i < 4; i++) begin
      if (load_ready === 1'b1) ready_cnt++;
      // A second load_start while loading must be ignored.
      load_start  = (i == 1);
      load_base   = '0;
      load_length = '0;
      load_valid  = 1'b1;
      load_data   = 32'h11 * (i + 1);
      tick();
    end
    load_start = 1'b0;
    load_valid = 1'b0;
    n_vec++; if (ready_cnt !== 4) begin n_err++; $display("FAIL burst_ready_cycles: got %0d want 4", ready_cnt); end
    n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL burst_done: got %b want 1", load_done); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL burst_stall_done: got %b want 1", stall); end
    n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL burst_ready_done: got %b want 0", load_ready); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL burst_fetch_valid: got %b want 0", fetch_valid); end
    tick();
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL burst_done_once: got %b want 0", load_done); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL burst_stall_end: got %b want 0", stall); end
    for (int i = 0; i < 4; i++) begin
      fetch_address = AW'(8 + i);
      tick();
      n_vec++; if (fetch_data !== 32'h11 * (i + 1)) begin n_err++; $display("FAIL burst_word%0d: got %h want %h", i, fetch_data, 32'h11 * (i + 1)); end
    end
    fetch_address = '0;
  endtask

  task automatic test_toggle();
    int w;
    int k;
    int ready_bad;
    logic [DW-1:0] exp_w [5];
    exp_w[0] = 32'hA1; exp_w[1] = 32'hA2; exp_w[2] = 32'hA3; exp_w[3] = 32'hA4;
    exp_w[4] = 32'h44440004;
    w = 0; k = 0; ready_bad = 0;
    start_load(10'd0, 11'd4);
    while (w < 4 && k < 16) begin
      if (load_ready !== 1'b1) ready_bad++;
      load_valid = ((k % 2) == 0);
      load_data  = load_valid ? 32'(32'hA1 + w) : 32'hBAD0BAD0;
      if (load_valid) w++;
      k++;
      tick();
    end
    load_valid = 1'b0;
    n_vec++; if (ready_bad !== 0) begin n_err++; $display("FAIL toggle_ready: got %0d low cycles want 0", ready_bad); end
    n_vec++; if (k !== 7) begin n_err++; $display("FAIL toggle_cycles: got %0d want 7", k); end
    n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL toggle_done: got %b want 1", load_done); end
    tick();
    for (int i = 0; i < 5; i++) begin
      fetch_address = AW'(i);
      tick();
      n_vec++; if (fetch_data !== exp_w[i]) begin n_err++; $display("FAIL toggle_word%0d: got %h want %h", i, fetch_data, exp_w[i]); end
    end
    fetch_address = '0;
  endtask

  task automatic test_zero_len();
    start_load(10'd2, 11'd0);
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL zero_stall: got %b want 1", stall); end
    n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", load_done); end
    n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL zero_ready: got %b want 0", load_ready); end
    tick();
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall_end: got %b want 0", stall); end
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL zero_done_end: got %b want 0", load_done); end
    fetch_address = 10'd2;
    tick();
    n_vec++; if (fetch_data !== 32'hA3) begin n_err++; $display("FAIL zero_mem: got %h want a3", fetch_data); end
    fetch_address = '0;
  endtask

  task automatic test_reset_abort();
    start_load(10'd12, 11'd5);
    load_valid = 1'b1; load_data = 32'hC1;
    // Direct write while loading must be ignored.
    write_enable = 1'b1; write_address = 10'd6; write_data = 32'hBADBAD00;
    tick();
    write_enable = 1'b0;
    load_data = 32'hC2;
    tick();
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL abort_stall: got %b want 0", stall); end
    n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", load_ready); end
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", load_done); end
    reset = 1'b0;
    tick();
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL abort_done_after: got %b want 0", load_done); end
    fetch_address = 10'd12;
    tick();
    n_vec++; if (fetch_data !== 32'hC1) begin n_err++; $display("FAIL abort_word0: got %h want c1", fetch_data); end
    fetch_address = 10'd13;
    tick();
    n_vec++; if (fetch_data !== 32'hC2) begin n_err++; $display("FAIL abort_word1: got %h want c2", fetch_data); end
    fetch_address = 10'd6;
    tick();
    n_vec++; if (fetch_data !== 32'h00000600) begin n_err++; $display("FAIL abort_dw_ignored: got %h want 00000600", fetch_data); end
    fetch_address = '0;
  endtask

  task automatic test_range();
    n_vec++; if (range_error !== 1'b0) begin n_err++; $display("FAIL range_clear: got %b want 0", range_error); end
    start_load(10'd14, 11'd4);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = 32'(32'hE1 + i);
      tick();
    end
    load_valid = 1'b0;
    n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL range_burst_done: got %b want 1", load_done); end
    n_vec++; if (range_error !== 1'b1) begin n_err++; $display("FAIL range_burst_err: got %b want 1", range_error); end
    tick();
    fetch_address = 10'd14; tick();
    n_vec++; if (fetch_data !== 32'hE1) begin n_err++; $display("FAIL range_word14: got %h want e1", fetch_data); end
    fetch_address = 10'd15; tick();
    n_vec++; if (fetch_data !== 32'hE2) begin n_err++; $display("FAIL range_word15: got %h want e2", fetch_data); end
    fetch_address = 10'd0; tick();
    n_vec++; if (fetch_data !== 32'hA1) begin n_err++; $display("FAIL range_no_alias0: got %h want a1", fetch_data); end
    fetch_address = 10'd1; tick();
    n_vec++; if (fetch_data !== 32'hA2) begin n_err++; $display("FAIL range_no_alias1: got %h want a2", fetch_data); end
    // Out-of-range fetch on its own.
    fetch_address = '0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    n_vec++; if (range_error !== 1'b0) begin n_err++; $display("FAIL range_reset_clears: got %b want 0", range_error); end
    fetch_address = 10'd20; tick();
    n_vec++; if (fetch_data !== '0) begin n_err++; $display("FAIL range_fetch20: got %h want 0", fetch_data); end
    n_vec++; if (range_error !== 1'b1) begin n_err++; $display("FAIL range_fetch_err: got %b want 1", range_error); end
    // Out-of-range direct write on its own; 30 would alias to 14.
    fetch_address = '0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    write_word(10'd30, 32'h30303030);
    n_vec++; if (range_error !== 1'b1) begin n_err++; $display("FAIL range_write_err: got %b want 1", range_error); end
    fetch_address = 10'd14; tick();
    n_vec++; if (fetch_data !== 32'hE1) begin n_err++; $display("FAIL range_write_dropped: got %h want e1", fetch_data); end
    fetch_address = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_direct_write();
    test_burst();
    test_toggle();
    test_zero_len();
    test_reset_abort();
    test_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
